// File: rtl/cosmac_bus_ctrl_if.sv
// Pin-side and memory-side signals of the COSMAC bus front end.
// master: the controller; slave: CPU pins plus memory array.
interface cosmac_bus_ctrl_if;
   logic        xclk;
   logic        nclear;
   logic        nwait;
   logic        nmrd;
   logic        nmwr;
   logic        tpa;
   logic        tpb;
   logic [7:0]  ma;
   logic [7:0]  db_in;
   logic [7:0]  db_out;
   logic        db_oe;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_rvalid;
   logic        bus_err;

   modport master (
      output xclk, nclear, nwait,
      output db_out, db_oe,
      output mem_addr, mem_re, mem_we, mem_wdata,
      output bus_err,
      input  nmrd, nmwr, tpa, tpb,
      input  ma, db_in,
      input  mem_rdata, mem_rvalid
   );

   modport slave (
      input  xclk, nclear, nwait,
      input  db_out, db_oe,
      input  mem_addr, mem_re, mem_we, mem_wdata,
      input  bus_err,
      output nmrd, nmwr, tpa, tpb,
      output ma, db_in,
      output mem_rdata, mem_rvalid
   );
endinterface

// File: rtl/cosmac_bus_ctrl.sv
// CDP1802 bus front end: XCLK/CLEAR generation, strobe sync,
// MA demux and single-cycle memory requests.
module cosmac_bus_ctrl #(
   parameter int XCLK_HALF = 4,
   parameter int CLR_XCLKS = 16
) (
   input  logic            clk_16mhz,
   input  logic            reset,
   cosmac_bus_ctrl_if.master bus
);

   localparam int CW = (XCLK_HALF > 1) ? $clog2(XCLK_HALF) : 1;
   localparam int NW = $clog2(CLR_XCLKS + 1);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_DRIVE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            xclk_q, xclk_d;
   logic [NW-1:0]   clr_cnt_q, clr_cnt_d;
   logic            nclear_q, nclear_d;
   logic [2:0]      mrd_sync_q, mrd_sync_d;
   logic [2:0]      mwr_sync_q, mwr_sync_d;
   logic [2:0]      tpa_sync_q, tpa_sync_d;
   logic [2:0]      tpb_sync_q, tpb_sync_d;
   logic [7:0]      addr_hi_q, addr_hi_d;
   logic [15:0]     mem_addr_q, mem_addr_d;
   logic [7:0]      mem_wdata_q, mem_wdata_d;
   logic            mem_re_q, mem_re_d;
   logic            mem_we_q, mem_we_d;
   logic [7:0]      db_out_q, db_out_d;
   logic            db_oe_q, db_oe_d;
   logic            bus_err_q, bus_err_d;

   logic            cnt_wrap;
   logic            xclk_fall;
   logic            mrd_s, mwr_s;
   logic            mrd_fall, tpa_fall, tpb_rise;

   // Bit 1 is the synchronised level, bit 2 the previous one.
   assign mrd_s    = mrd_sync_q[1];
   assign mwr_s    = mwr_sync_q[1];
   assign mrd_fall = mrd_sync_q[2] & ~mrd_sync_q[1];
   assign tpa_fall = tpa_sync_q[2] & ~tpa_sync_q[1];
   assign tpb_rise = ~tpb_sync_q[2] & tpb_sync_q[1];

   assign cnt_wrap  = (cnt_q == CW'(XCLK_HALF - 1));
   assign xclk_fall = cnt_wrap & xclk_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      xclk_d      = xclk_q;
      clr_cnt_d   = clr_cnt_q;
      nclear_d    = nclear_q;
      addr_hi_d   = addr_hi_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      db_out_d    = db_out_q;
      db_oe_d     = db_oe_q;
      bus_err_d   = bus_err_q;
      mrd_sync_d  = {mrd_sync_q[1:0], bus.nmrd};
      mwr_sync_d  = {mwr_sync_q[1:0], bus.nmwr};
      tpa_sync_d  = {tpa_sync_q[1:0], bus.tpa};
      tpb_sync_d  = {tpb_sync_q[1:0], bus.tpb};

      if (cnt_wrap) begin
         cnt_d  = '0;
         xclk_d = ~xclk_q;
      end

      if (xclk_fall && !nclear_q) begin
         if (clr_cnt_q == NW'(CLR_XCLKS - 1)) begin
            nclear_d = 1'b1;
         end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
         end
      end

      if (tpa_fall) begin
         addr_hi_d = bus.ma;
      end

      unique case (state_q)
         IDLE: begin
            if (mrd_fall) begin
               state_d    = RD_WAIT;
               mem_re_d   = 1'b1;
               mem_addr_d = {addr_hi_q, bus.ma};
            end
         end
         RD_WAIT: begin
            if (mrd_s) begin
               state_d = IDLE;
            end else if (bus.mem_rvalid) begin
               state_d  = RD_DRIVE;
               db_out_d = bus.mem_rdata;
               db_oe_d  = 1'b1;
            end
         end
         RD_DRIVE: begin
            if (mrd_s) begin
               state_d = IDLE;
               db_oe_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // A write overlapping an active read is a CPU protocol error.
      if (tpb_rise && !mwr_s) begin
         if (!mrd_s) begin
            bus_err_d = 1'b1;
         end else if (state_q == IDLE) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {addr_hi_q, bus.ma};
            mem_wdata_d = bus.db_in;
         end
      end
   end

   always_ff @(posedge clk_16mhz or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         xclk_q      <= 1'b0;
         clr_cnt_q   <= '0;
         nclear_q    <= 1'b0;
         mrd_sync_q  <= 3'b111;
         mwr_sync_q  <= 3'b111;
         tpa_sync_q  <= 3'b000;
         tpb_sync_q  <= 3'b000;
         addr_hi_q   <= 8'h00;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 8'h00;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         db_out_q    <= 8'h00;
         db_oe_q     <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         xclk_q      <= xclk_d;
         clr_cnt_q   <= clr_cnt_d;
         nclear_q    <= nclear_d;
         mrd_sync_q  <= mrd_sync_d;
         mwr_sync_q  <= mwr_sync_d;
         tpa_sync_q  <= tpa_sync_d;
         tpb_sync_q  <= tpb_sync_d;
         addr_hi_q   <= addr_hi_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         db_out_q    <= db_out_d;
         db_oe_q     <= db_oe_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.xclk      = xclk_q;
   assign bus.nclear    = nclear_q;
   assign bus.nwait     = 1'b1;
   assign bus.db_out    = db_out_q;
   assign bus.db_oe     = db_oe_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_cosmac_bus_ctrl.sv
// Randomised bench for cosmac_bus_ctrl against a
// transaction-level model of the CPU bus rules.
module tb_cosmac_bus_ctrl;

   logic clk;
   logic reset;

   cosmac_bus_ctrl_if bus ();

   cosmac_bus_ctrl #(
      .XCLK_HALF (4),
      .CLR_XCLKS (16)
   ) dut (
      .clk_16mhz (clk),
      .reset     (reset),
      .bus       (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs;
   int checks;
   int re_cnt;
   int we_cnt;
   int oe_cnt;
   int clash;
   int nwait_bad;

   logic [7:0] m_hi;
   logic [7:0] m_db;
   logic       m_err;

   initial begin
      errs = 0; checks = 0;
      re_cnt = 0; we_cnt = 0; oe_cnt = 0;
      clash = 0; nwait_bad = 0;
   end

   always @(negedge clk) begin
      if (bus.mem_re) re_cnt++;
      if (bus.mem_we) we_cnt++;
      if (bus.db_oe) oe_cnt++;
      if (bus.mem_re && bus.mem_we) clash++;
      if (!bus.nwait) nwait_bad++;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_tpa(input logic [7:0] hi);
      bus.ma  = hi;
      bus.tpa = 1'b1;
      tick(); tick();
      bus.tpa = 1'b0;
      repeat (4) tick();
      m_hi = hi;
   endtask

   task automatic wait_re(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.mem_re && n < 12);
   endtask

   task automatic measure_clear(output int rise_at,
                                output int period,
                                output int falls);
      logic prev;
      int   r2;
      rise_at = -1; r2 = -1; falls = 0; prev = 1'b0;
      for (int n = 1; n <= 400; n++) begin
         tick();
         if (prev && !bus.xclk) falls++;
         if (!prev && bus.xclk) begin
            if (rise_at < 0) rise_at = n;
            else if (r2 < 0) r2 = n;
         end
         prev = bus.xclk;
         if (bus.nclear) break;
      end
      period = r2 - rise_at;
   endtask

   task automatic do_read(input logic [7:0] hi, lo, d,
                          input int lat, input bit tpa_en,
                          input bit abort);
      int n, r0, o0;
      if (tpa_en) pulse_tpa(hi);
      r0 = re_cnt; o0 = oe_cnt;
      bus.ma = lo;
      bus.nmrd = 1'b0;
      wait_re(n);
      chk("rd_re_lat", n, 3);
      chk("rd_addr", 32'(bus.mem_addr), 32'({m_hi, lo}));
      if (abort) begin
         tick();
         bus.nmrd = 1'b1;
         repeat (6) tick();
         bus.mem_rdata = d;
         bus.mem_rvalid = 1'b1;
         tick();
         bus.mem_rvalid = 1'b0;
         repeat (4) tick();
         chk("ab_oe_cycles", oe_cnt - o0, 0);
         chk("ab_dbout", 32'(bus.db_out), 32'(m_db));
         chk("ab_re_once", re_cnt - r0, 1);
      end else begin
         repeat (lat) tick();
         bus.mem_rdata = d;
         bus.mem_rvalid = 1'b1;
         tick();
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata = ~d;
         chk("rd_oe", 32'(bus.db_oe), 1);
         chk("rd_dout", 32'(bus.db_out), 32'(d));
         repeat (3) tick();
         chk("rd_oe_hold", 32'(bus.db_oe), 1);
         chk("rd_re_once", re_cnt - r0, 1);
         bus.nmrd = 1'b1;
         n = 0;
         do begin
            tick();
            n++;
         end while (bus.db_oe && n < 12);
         chk("rd_oe_drop", n, 3);
         chk("rd_dout_hold", 32'(bus.db_out), 32'(d));
         m_db = d;
         repeat (2) tick();
      end
      chk("rd_err", 32'(bus.bus_err), 32'(m_err));
   endtask

   task automatic do_write(input logic [7:0] hi, lo, d,
                           input bit tpa_en);
      int n, r0, w0;
      if (tpa_en) pulse_tpa(hi);
      r0 = re_cnt; w0 = we_cnt;
      bus.ma = lo;
      bus.db_in = d;
      bus.nmwr = 1'b0;
      repeat (2) tick();
      bus.tpb = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.mem_we && n < 12);
      chk("wr_we_lat", n, 3);
      chk("wr_addr", 32'(bus.mem_addr), 32'({m_hi, lo}));
      chk("wr_data", 32'(bus.mem_wdata), 32'(d));
      bus.tpb = 1'b0;
      repeat (3) tick();
      bus.nmwr = 1'b1;
      bus.db_in = ~d;
      repeat (4) tick();
      chk("wr_we_once", we_cnt - w0, 1);
      chk("wr_no_re", re_cnt - r0, 0);
      chk("wr_wdata_stable", 32'(bus.mem_wdata), 32'(d));
      chk("wr_err", 32'(bus.bus_err), 32'(m_err));
   endtask

   task automatic do_err(input logic [7:0] hi, lo, d,
                         input int lat, input bit tpa_en);
      int n, w0;
      if (tpa_en) pulse_tpa(hi);
      w0 = we_cnt;
      bus.ma = lo;
      bus.db_in = ~d;
      bus.nmrd = 1'b0;
      bus.nmwr = 1'b0;
      wait_re(n);
      chk("er_re_lat", n, 3);
      chk("er_addr", 32'(bus.mem_addr), 32'({m_hi, lo}));
      repeat (lat) tick();
      bus.mem_rdata = d;
      bus.mem_rvalid = 1'b1;
      tick();
      bus.mem_rvalid = 1'b0;
      chk("er_oe", 32'(bus.db_oe), 1);
      bus.tpb = 1'b1;
      repeat (5) tick();
      bus.tpb = 1'b0;
      m_err = 1'b1;
      chk("er_flag", 32'(bus.bus_err), 1);
      chk("er_dout", 32'(bus.db_out), 32'(d));
      bus.nmrd = 1'b1;
      bus.nmwr = 1'b1;
      repeat (5) tick();
      m_db = d;
      chk("er_no_we", we_cnt - w0, 0);
      chk("er_oe_off", 32'(bus.db_oe), 0);
      chk("er_sticky", 32'(bus.bus_err), 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rise_at, period, falls, n, r0, op, w0;
      logic [7:0] hi, lo, d;
      bit tp;

      reset = 1'b1;
      bus.nmrd = 1'b1; bus.nmwr = 1'b1;
      bus.tpa = 1'b0; bus.tpb = 1'b0;
      bus.ma = 8'h00; bus.db_in = 8'h00;
      bus.mem_rdata = 8'h00; bus.mem_rvalid = 1'b0;
      m_hi = 8'h00; m_db = 8'h00; m_err = 1'b0;

      repeat (2) tick();
      chk("rst_xclk", 32'(bus.xclk), 0);
      chk("rst_nclear", 32'(bus.nclear), 0);
      chk("rst_nwait", 32'(bus.nwait), 1);
      chk("rst_db_out", 32'(bus.db_out), 0);
      chk("rst_db_oe", 32'(bus.db_oe), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_re_we", 32'({bus.mem_re, bus.mem_we}), 0);
      chk("rst_wdata", 32'(bus.mem_wdata), 0);
      chk("rst_err", 32'(bus.bus_err), 0);
      repeat (3) tick();
      reset = 1'b0;

      measure_clear(rise_at, period, falls);
      chk("xclk_first_rise", rise_at, 4);
      chk("xclk_period", period, 8);
      chk("clr_falls", falls, 16);
      chk("clr_done", 32'(bus.nclear), 1);

      do_read(8'h12, 8'h34, 8'hA5, 2, 1'b1, 1'b0);
      do_write(8'h00, 8'h07, 8'h3C, 1'b1);
      do_err(8'h40, 8'h41, 8'h5E, 1, 1'b1);
      do_read(8'h77, 8'h88, 8'hC1, 3, 1'b1, 1'b1);

      for (int i = 0; i < 24; i++) begin
         op = int'($urandom_range(0, 4));
         hi = 8'($urandom);
         lo = 8'($urandom);
         d  = 8'($urandom);
         tp = ($urandom_range(0, 3) != 0);
         n  = int'($urandom_range(1, 8));
         case (op)
            0: do_read(hi, lo, d, n, tp, 1'b0);
            1: do_write(hi, lo, d, tp);
            2: do_err(hi, lo, d, n, tp);
            3: do_read(hi, lo, d, n, tp, 1'b1);
            default: begin
               r0 = re_cnt; w0 = we_cnt;
               pulse_tpa(hi);
               repeat (4) tick();
               chk("tpa_only_quiet", (re_cnt - r0) + (we_cnt - w0), 0);
            end
         endcase
      end

      pulse_tpa(8'h5A);
      bus.ma = 8'hC3;
      bus.nmrd = 1'b0;
      wait_re(n);
      chk("rs_addr", 32'(bus.mem_addr), 32'h5AC3);
      bus.mem_rdata = 8'h99;
      bus.mem_rvalid = 1'b1;
      tick();
      bus.mem_rvalid = 1'b0;
      chk("rs_pre_oe", 32'(bus.db_oe), 1);
      r0 = re_cnt;
      #2;
      reset = 1'b1;
      bus.nmrd = 1'b1;
      #1;
      chk("rs_oe", 32'(bus.db_oe), 0);
      chk("rs_nclear", 32'(bus.nclear), 0);
      chk("rs_xclk", 32'(bus.xclk), 0);
      chk("rs_dbout", 32'(bus.db_out), 0);
      chk("rs_err", 32'(bus.bus_err), 0);
      m_err = 1'b0; m_db = 8'h00; m_hi = 8'h00;
      repeat (4) tick();
      reset = 1'b0;
      measure_clear(rise_at, period, falls);
      chk("rs_first_rise", rise_at, 4);
      chk("rs_clr_falls", falls, 16);
      chk("rs_clr_done", 32'(bus.nclear), 1);
      chk("rs_no_re", re_cnt - r0, 0);

      chk("re_we_clash", clash, 0);
      chk("nwait_low", nwait_bad, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/cosmac_bus_ctrl.md
# cosmac_bus_ctrl

Bus-side front end of the Cosmem chip, sitting between the CDP1802 pins and the internal memory array. It generates the CPU clock (XCLK) and the power-on CLEAR/WAIT sequence. It synchronises the asynchronous CPU strobes into the `clk_16mhz` domain and demultiplexes the two-phase MA bus into a 16-bit address. It then issues single-cycle read/write requests to the memory and drives the data bus during CPU reads.

## Interface

Parameters:
- `XCLK_HALF`, 4: `clk_16mhz` cycles per XCLK half-period (default gives a 2 MHz XCLK).
- `CLR_XCLKS`, 16: XCLK periods that `nclear` stays low after reset release.

Ports:
- `clk_16mhz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `xclk`  out  1  CPU clock.
- `nclear`  out  1  CPU CLEAR, active low.
- `nwait`  out  1  CPU WAIT, active low.
- `nmrd`, `nmwr`, `tpa`, `tpb`  in  1 each  CPU strobes, asynchronous.
- `ma`  in  8  multiplexed memory address.
- `db_in`  in  8  data bus sampled from the pins.
- `db_out`  out  8  data driven to the bus.
- `db_oe`  out  1  tristate enable for `db_out`.
- `mem_addr`  out  16  request address.
- `mem_re`  out  1  read request, 1-cycle pulse.
- `mem_we`  out  1  write request, 1-cycle pulse.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data.
- `mem_rvalid`  in  1  `mem_rdata` valid, 1-cycle pulse.
- `bus_err`  out  1  sticky protocol-error flag.

## Operation

- **Clock generator:**
  - Counter of width ≥ clog2(`XCLK_HALF`).
  - `xclk` toggles every `XCLK_HALF` cycles.
  - `xclk` is held 0 during reset and first rises `XCLK_HALF` cycles after reset falls.
- **Clear sequence:**
  - `nclear` = 0 from reset until `CLR_XCLKS` falling edges of `xclk` have been counted, then 1 until the next reset.
  - `nwait` = 1 at all times after reset (run/reset modes only).
- **Synchroniser:**
  - `nmrd`, `nmwr`, `tpa`, `tpb` each pass through 2 flops.
  - One more flop provides edge detection.
  - `ma` and `db_in` are sampled unsynchronised, only at detected edges; the CPU guarantees they are stable by then.
- **Address demux:**
  - On synced `tpa` falling edge, `addr_hi` <= `ma`.
  - Low byte is captured at the start of the access: `nmrd` falling for reads, `tpb` rising for writes.
- **Read FSM:** states IDLE, RD_WAIT, RD_DRIVE.
  - IDLE → RD_WAIT on synced `nmrd` falling edge. Actions: `mem_addr` = {`addr_hi`, `ma`}, `mem_re` pulses 1 cycle.
  - RD_WAIT → RD_DRIVE on `mem_rvalid`. Actions: `db_out` <= `mem_rdata`, `db_oe` = 1.
  - RD_WAIT or RD_DRIVE → IDLE when synced `nmrd` = 1. `db_oe` drops in the same cycle; `db_out` holds its value.
- **Write path:**
  - On synced `tpb` rising edge while synced `nmwr` = 0 and FSM in IDLE: `mem_addr` = {`addr_hi`, `ma`}, `mem_wdata` = `db_in`, `mem_we` pulses 1 cycle.
- **Boundaries:**
  - Synced `nmrd` and `nmwr` both 0 at a `tpb` rise: the write is suppressed, the read proceeds, and `bus_err` <= 1.
  - `mem_rvalid` outside RD_WAIT is ignored.
  - `nmrd` rising while in RD_WAIT: return to IDLE, never drive the bus; a late `mem_rvalid` is ignored.
  - A `tpa` edge without a following access only updates `addr_hi`.
  - `addr_hi` does not wrap or increment; it is whatever the last TPA supplied.
- **Reset (asynchronous, may occur mid-access):**
  - All outputs go to reset values immediately and the FSM returns to IDLE.
  - No pending `mem_re`/`mem_we` pulse is emitted after reset.
  - Reset values: `xclk` 0, `nclear` 0, `nwait` 1, `db_out` 0x00, `db_oe` 0, `mem_addr` 0x0000, `mem_re` 0, `mem_we` 0, `mem_wdata` 0x00, `bus_err` 0.

## Timing

- Pin edge to internal action: 3 `clk_16mhz` cycles (2 sync + 1 edge detect).
- `mem_re` to `db_oe`: equals memory latency + 1 cycle. Memory latency must be ≤ 8 cycles so data is on the bus before the CPU samples at TPB.
- `nmrd` rise to `db_oe` = 0: 3 cycles. This is within one XCLK half-period, so there is no contention with the following write data.
- `mem_re` and `mem_we` are never high in the same cycle.
- `mem_addr` and `mem_wdata` remain stable until the next request.

## Test plan

- Reset 5 cycles then release -> `xclk` period 8 cycles; `nclear` rises after exactly 16 `xclk` falls; `nwait` = 1 throughout.
- `tpa` pulse with `ma`=0x12, then `nmrd` low with `ma`=0x34, memory returns 0xA5 after 2 cycles -> `mem_re` single pulse with `mem_addr`=0x1234; `db_out`=0xA5 and `db_oe`=1 until 3 cycles after `nmrd` rises.
- `tpa` with `ma`=0x00, `nmwr` low with `ma`=0x07 and `db_in`=0x3C, `tpb` pulse -> one `mem_we` pulse with `mem_addr`=0x0007 and `mem_wdata`=0x3C; `mem_re` stays 0.
- `nmrd` and `nmwr` both low at a `tpb` rise -> no `mem_we`; `bus_err`=1 and stays 1 until reset.
- `nmrd` released before `mem_rvalid` arrives -> `db_oe` never asserts; the late `mem_rvalid` changes nothing.
- `reset` asserted in RD_DRIVE -> `db_oe`=0 and `nclear`=0 immediately; after release the clear sequence restarts from count 0.
